data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_if.sv | 27 ++
 rtl/data_mem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Load/store request and response bus between a core pipeline and data_mem_ctrl.
// A request transfers on a rising edge where req_valid && req_ready; a response
// transfers on a rising edge where rsp_valid && rsp_ready, and it is held stable until then.
interface data_mem_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       Funct3;
  logic [WIDTH-1:0] Mem_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rd_data;
  logic             rsp_err;

  modport slave (
    input  req_valid, req_we, Funct3, Mem_addr, wr_data, rsp_ready,
    output req_ready, rsp_valid, rd_data, rsp_err
  );

  modport master (
    output req_valid, req_we, Funct3, Mem_addr, wr_data, rsp_ready,
    input  req_ready, rsp_valid, rd_data, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-outstanding data memory controller with byte/halfword/word loads and stores.
// Define DATA_MEM_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of aligning them down.
module data_mem_ctrl #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_ctrl_if.slave bus,
  output logic [1:0]    dbg_state
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t           state, state_nx;
  logic [3:0]       cnt, cnt_nx;
  logic             accept, enter_resp, mem_we;

  logic             we_q;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] addr_q, wdata_q;

  logic             a_we;
  logic [2:0]       a_f3;
  logic [WIDTH-1:0] a_addr, a_wdata;

  logic [AW-1:0]    idx;
  logic [1:0]       off, eff_off;
  logic             bad_f3, misal, err;
  logic [WIDTH-1:0] word, load_val, rd_nx, store_word;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  logic             rsp_valid_q, rsp_err_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             unused_addr_bits;

  logic [WIDTH-1:0] mem [DEPTH];

  // With zero wait states the access happens on the accept edge, so use the live bus fields.
  always_comb begin
    a_we    = (state == IDLE) ? bus.req_we   : we_q;
    a_f3    = (state == IDLE) ? bus.Funct3   : f3_q;
    a_addr  = (state == IDLE) ? bus.Mem_addr : addr_q;
    a_wdata = (state == IDLE) ? bus.wr_data  : wdata_q;
  end

  assign idx              = a_addr[AW+1:2];
  assign off              = a_addr[1:0];
  assign word             = mem[idx];
  assign unused_addr_bits = ^a_addr[WIDTH-1:AW+2];

  always_comb begin
    bad_f3 = a_we ? (a_f3 > 3'd2) : ((a_f3 == 3'd3) || (a_f3 > 3'd5));
    misal  = ((a_f3[1:0] == 2'd1) && off[0]) || ((a_f3[1:0] == 2'd2) && (off != 2'd0));
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    err     = bad_f3 || misal;
    eff_off = off;
`else
    err     = bad_f3;
    eff_off = off;
    if (a_f3[1:0] == 2'd1) eff_off = {off[1], 1'b0};
    else if (a_f3[1:0] == 2'd2) eff_off = 2'd0;
`endif
  end

  always_comb begin
    byte_sel = word[{eff_off, 3'b000} +: 8];
    half_sel = word[{eff_off[1], 4'b0000} +: 16];
    load_val = '0;
    case (a_f3)
      3'd0:    load_val = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      3'd1:    load_val = {{(WIDTH-16){half_sel[15]}}, half_sel};
      3'd2:    load_val = word;
      3'd4:    load_val = {{(WIDTH-8){1'b0}}, byte_sel};
      3'd5:    load_val = {{(WIDTH-16){1'b0}}, half_sel};
      default: load_val = '0;
    endcase
    rd_nx = (a_we || err) ? '0 : load_val;

    store_word = word;
    case (a_f3)
      3'd0:    store_word[{eff_off, 3'b000} +: 8]     = a_wdata[7:0];
      3'd1:    store_word[{eff_off[1], 4'b0000} +: 16] = a_wdata[15:0];
      3'd2:    store_word = a_wdata;
      default: store_word = word;
    endcase
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          cnt_nx = 4'd0;
          if (WAIT_CYCLES == 0) begin
            state_nx   = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'(WAIT_CYCLES - 1)) begin
          state_nx   = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Gating with rst keeps a store issued during reset from reaching memory.
  assign mem_we = enter_resp && a_we && !err && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.Funct3;
        addr_q  <= bus.Mem_addr;
        wdata_q <= bus.wr_data;
      end
      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= err;
        rd_data_q   <= rd_nx;
      end else if ((state == RESP) && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
        rsp_err_q   <= 1'b0;
        rd_data_q   <= '0;
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= store_word;
  end

  assign bus.req_ready = (state == IDLE) && rst;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rd_data   = rd_data_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: byte-array reference model, per-cycle compare process,
// directed pins for the documented scenarios, then randomized load/store traffic.
module tb_data_mem_ctrl;
  localparam int WIDTH       = 32;
  localparam int DEPTH       = 256;
  localparam int WAIT_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;

  data_mem_ctrl_if #(.WIDTH(WIDTH)) bus();

  data_mem_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_err_q[$];
  logic [7:0]       ref_mem [4*DEPTH];

  task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: memory as a flat byte array, accesses as byte runs.
  function automatic void model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                       input logic [31:0] wd, output logic [31:0] d, output logic e);
    int a, size;
    logic legal;
    logic [31:0] v;
    a = int'(addr & 32'(4*DEPTH - 1));
    case (f3[1:0])
      2'd0: size = 1;
      2'd1: size = 2;
      2'd2: size = 4;
      default: size = 0;
    endcase
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (legal) begin
`ifdef DATA_MEM_MISALIGN_TRAP_EN
      if ((a % size) != 0) legal = 1'b0;
`else
      a = a - (a % size);
`endif
    end
    d = '0;
    e = !legal;
    if (legal) begin
      if (we) begin
        for (int i = 0; i < size; i++) ref_mem[a+i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < size; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
        if (!f3[2] && (size < 4) && v[8*size-1]) v = v | ~((32'h1 << (8*size)) - 32'h1);
        d = v;
      end
    end
  endfunction

  // compare process: every cycle, outputs against the model's expectation queue
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_without_request", 32'(exp_q.size()), 32'd1);
        end else begin
          check("rd_data", bus.rd_data, exp_q[0]);
          check("rsp_err", 32'(bus.rsp_err), 32'(exp_err_q[0]));
          if (bus.rsp_ready) begin
            void'(exp_q.pop_front());
            void'(exp_err_q.pop_front());
          end
        end
      end else begin
        check("idle_rd_data", bus.rd_data, '0);
        check("idle_rsp_err", 32'(bus.rsp_err), 32'd0);
      end
    end
  end

  // driver: one full request/response transaction with timing checks
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] got_d, output logic got_e);
    int n;
    logic [31:0] ed;
    logic ee;
    got_d = '0;
    got_e = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.Funct3    = f3;
    bus.Mem_addr  = addr;
    bus.wr_data   = wd;
    bus.rsp_ready = (hold == 0);
    #1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    model_access(we, f3, addr, wd, ed, ee);
    exp_q.push_back(ed);
    exp_err_q.push_back(ee);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    n = 1;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rsp_latency", 32'(n), 32'(WAIT_CYCLES + 1));
    if (!bus.rsp_valid) begin
      exp_q.delete();
      exp_err_q.delete();
      return;
    end
    got_d = bus.rd_data;
    got_e = bus.rsp_err;
    check("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        #1;
        check("hold_rd_data", bus.rd_data, got_d);
        check("hold_valid_ready", {30'd0, bus.rsp_valid, bus.req_ready}, 32'b10);
      end
      @(negedge clk);
      bus.rsp_ready = 1'b1;
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    check("idle_after_rsp", {30'd0, bus.rsp_valid, bus.req_ready}, 32'b01);
  endtask

  task automatic reset_in_wait(input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.Funct3    = 3'd2;
    bus.Mem_addr  = addr;
    bus.wr_data   = wd;
    bus.rsp_ready = 1'b1;
    #1;
    check("rw_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("rw_rsp_flags", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
    check("rw_rd_data", bus.rd_data, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    #1;
    check("rw_ready_after", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic reset_mid_resp(input logic [31:0] addr);
    int n;
    logic [31:0] ed;
    logic ee;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.Funct3    = 3'd2;
    bus.Mem_addr  = addr;
    bus.rsp_ready = 1'b0;
    model_access(1'b0, 3'd2, addr, '0, ed, ee);
    exp_q.push_back(ed);
    exp_err_q.push_back(ee);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rr_reached_resp", 32'(bus.rsp_valid), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rr_rd_data", bus.rd_data, '0);
    exp_q.delete();
    exp_err_q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rr_ready_after", 32'(bus.req_ready), 32'd1);
  endtask

  logic [31:0] d;
  logic        e;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.Funct3    = 3'd0;
    bus.Mem_addr  = '0;
    bus.wr_data   = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_rsp_flags", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
    check("reset_rd_data", bus.rd_data, '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ready_after_reset", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < DEPTH; i++) do_req(1'b1, 3'd2, 32'(i * 4), $urandom(), 0, d, e);

    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, d, e);
    check("sw_rd_data_zero", d, 32'h0);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, d, e);
    check("lw_0x10", d, 32'hDEADBEEF);
    do_req(1'b1, 3'd0, 32'h13, 32'h0000007F, 0, d, e);
    do_req(1'b0, 3'd0, 32'h13, 32'h0, 0, d, e);
    check("lb_0x13", d, 32'h0000007F);
    do_req(1'b0, 3'd4, 32'h12, 32'h0, 0, d, e);
    check("lbu_0x12", d, 32'h000000AD);
    do_req(1'b0, 3'd1, 32'h10, 32'h0, 0, d, e);
    check("lh_0x10", d, 32'hFFFFBEEF);
    do_req(1'b0, 3'd2, 32'h11, 32'h0, 0, d, e);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    check("lw_0x11_data", d, 32'h0);
    check("lw_0x11_err", 32'(e), 32'd1);
`else
    check("lw_0x11_data", d, 32'h7FADBEEF);
    check("lw_0x11_err", 32'(e), 32'd0);
`endif
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 5, d, e);
    check("lw_hold5", d, 32'h7FADBEEF);
    do_req(1'b0, 3'd3, 32'h0, 32'h0, 0, d, e);
    check("bad_f3_data", d, 32'h0);
    check("bad_f3_err", 32'(e), 32'd1);
    do_req(1'b0, 3'd2, 32'(4*DEPTH + 'h10), 32'h0, 0, d, e);
    check("lw_wrap", d, 32'h7FADBEEF);

    do_req(1'b1, 3'd2, 32'h20, 32'hCAFEF00D, 0, d, e);
    reset_in_wait(32'h20, 32'h12345678);
    do_req(1'b0, 3'd2, 32'h20, 32'h0, 0, d, e);
    check("lw_0x20_after_reset", d, 32'hCAFEF00D);
    reset_mid_resp(32'h10);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, d, e);
    check("lw_after_mid_resp_reset", d, 32'h7FADBEEF);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 8*DEPTH - 1));
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom(),
             $urandom_range(0, 3), d, e);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
